// File: rtl/jts16_busarb_pkg.sv
// jts16_busarb_pkg: shared state encoding and helpers for the sub-CPU bus arbiter.
package jts16_busarb_pkg;

    typedef enum logic [1:0] {IDLE, REQ, OWN, REL} state_t;

    localparam int MAXCH = 8;

    function automatic int sel_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    function automatic logic [MAXCH-1:0] onehot(input int idx);
        return MAXCH'(1) << idx;
    endfunction

endpackage

// File: rtl/jts16_rrpick.sv
// jts16_rrpick: combinational round-robin picker, first request after last with wrap-around.
module jts16_rrpick #(
    parameter int NCH = 2,
    parameter int SW  = 1
)(
    input  logic [NCH-1:0] req,
    input  logic [SW-1:0]  last,
    output logic [SW-1:0]  sel,
    output logic           any
);

    logic [SW-1:0] idx;

    // Scan from the farthest candidate inward so the nearest one after last wins.
    always_comb begin
        sel = last;
        any = 1'b0;
        idx = last;
        for (int k = NCH; k >= 1; k--) begin
            idx = SW'((int'(last) + k) % NCH);
            if (req[idx]) begin
                sel = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jts16_busarb.sv
// jts16_busarb: 68000 BR/BG/BGACK arbiter with round-robin over NCH external masters
// and a combinational mux steering the owner onto the local bus.
module jts16_busarb
    import jts16_busarb_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int AW     = 19,
    parameter int DW     = 16,
    parameter int MAXTEN = 0,
    parameter int GAP    = 1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic              cpu_ASn,
    input  logic              cpu_BGn,
    output logic              cpu_BRn,
    output logic              cpu_BGACKn,
    input  logic [AW-1:0]     cpu_addr,
    input  logic [1:0]        cpu_dsn,
    input  logic              cpu_rnw,
    input  logic [DW-1:0]     cpu_dout,
    input  logic [NCH-1:0]    req,
    input  logic [NCH*AW-1:0] ext_addr,
    input  logic [NCH*2-1:0]  ext_dsn,
    input  logic [NCH-1:0]    ext_rnw,
    input  logic [NCH*DW-1:0] ext_dout,
    input  logic              bus_busy,
    output logic [NCH-1:0]    gnt,
    output logic [NCH-1:0]    ext_ok,
    output logic [AW-1:0]     bus_addr,
    output logic [1:0]        bus_dsn,
    output logic              bus_rnw,
    output logic [DW-1:0]     bus_dout
);

    localparam int            SW    = sel_width(NCH);
    localparam logic [SW-1:0] LAST0 = SW'(NCH - 1);
    localparam logic [7:0]    MAXT  = 8'(MAXTEN);
    localparam logic [3:0]    GAPV  = 4'(GAP);

    state_t         state;
    logic [SW-1:0]  sel, last, pick;
    logic           any, others, expire;
    logic [7:0]     tenure, ten_nx;
    logic [3:0]     gap;
    logic [NCH-1:0] gnt_d, sel_oh;

    jts16_rrpick #(.NCH(NCH), .SW(SW)) u_pick (
        .req  (req),
        .last (last),
        .sel  (pick),
        .any  (any)
    );

    assign sel_oh = NCH'(onehot(int'(sel)));
    assign others = |(req & ~sel_oh);
    assign ten_nx = tenure + {7'd0, tenure != 8'hff};
    // A waiting channel may preempt only once memory is idle, so no access is cut short.
    assign expire = (MAXTEN != 0) && (ten_nx >= MAXT) && others && !bus_busy;
    assign ext_ok = gnt & gnt_d & {NCH{~bus_busy}};

    assign bus_addr = cpu_BGACKn ? cpu_addr : ext_addr[int'(sel)*AW +: AW];
    assign bus_dsn  = cpu_BGACKn ? cpu_dsn  : ext_dsn[int'(sel)*2 +: 2];
    assign bus_rnw  = cpu_BGACKn ? cpu_rnw  : ext_rnw[sel];
    assign bus_dout = cpu_BGACKn ? cpu_dout : ext_dout[int'(sel)*DW +: DW];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cpu_BRn    <= 1'b1;
            cpu_BGACKn <= 1'b1;
            gnt        <= '0;
            gnt_d      <= '0;
            sel        <= LAST0;
            last       <= LAST0;
            tenure     <= '0;
            gap        <= '0;
        end else begin
            gnt_d <= gnt;
            if (cen) begin
                case (state)
                    IDLE: if (any) begin
                        sel     <= pick;
                        cpu_BRn <= 1'b0;
                        state   <= REQ;
                    end
                    REQ: if (!req[sel]) begin
                        cpu_BRn <= 1'b1;
                        state   <= IDLE;
                    end else if (!cpu_BGn && cpu_ASn) begin
                        cpu_BGACKn <= 1'b0;
                        cpu_BRn    <= 1'b1;
                        gnt        <= sel_oh;
                        tenure     <= '0;
                        state      <= OWN;
                    end
                    OWN: begin
                        tenure <= ten_nx;
                        if (!req[sel] || expire) begin
                            cpu_BGACKn <= 1'b1;
                            gnt        <= '0;
                            last       <= sel;
                            gap        <= GAPV;
                            state      <= REL;
                        end
                    end
                    REL: begin
                        gap   <= gap - 4'd1;
                        state <= gap < 4'd2 ? IDLE : REL;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jts16_busarb.sv
// tb_jts16_busarb: randomized requesters and CPU against a round-robin/tenure reference model.
module tb_jts16_busarb;

    localparam int NCH = 3, AW = 19, DW = 16, MAXTEN = 4, GAP = 2;

    logic clk = 1'b0;
    logic rst, cen, cpu_ASn, cpu_BGn, cpu_BRn, cpu_BGACKn, cpu_rnw, bus_busy, bus_rnw;
    logic [AW-1:0] cpu_addr, bus_addr;
    logic [1:0] cpu_dsn, bus_dsn;
    logic [DW-1:0] cpu_dout, bus_dout;
    logic [NCH-1:0] req, ext_rnw, gnt, ext_ok;
    logic [NCH*AW-1:0] ext_addr;
    logic [NCH*2-1:0] ext_dsn;
    logic [NCH*DW-1:0] ext_dout;

    jts16_busarb #(.NCH(NCH), .AW(AW), .DW(DW), .MAXTEN(MAXTEN), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .cen(cen), .cpu_ASn(cpu_ASn), .cpu_BGn(cpu_BGn),
        .cpu_BRn(cpu_BRn), .cpu_BGACKn(cpu_BGACKn), .cpu_addr(cpu_addr), .cpu_dsn(cpu_dsn),
        .cpu_rnw(cpu_rnw), .cpu_dout(cpu_dout), .req(req), .ext_addr(ext_addr),
        .ext_dsn(ext_dsn), .ext_rnw(ext_rnw), .ext_dout(ext_dout), .bus_busy(bus_busy),
        .gnt(gnt), .ext_ok(ext_ok), .bus_addr(bus_addr), .bus_dsn(bus_dsn),
        .bus_rnw(bus_rnw), .bus_dout(bus_dout)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [AW-1:0] ea[NCH];
    logic [1:0]    ed[NCH];
    logic          er[NCH];
    logic [DW-1:0] eo[NCH];

    int exp_q[$];
    int m_last, saved_last, pend, br_ticks;
    int len[NCH], served[NCH], cool[NCH];
    logic prev_brn, last_cen;

    bit mon_en = 1'b0;
    bit own, prev_own;
    int own_ch, ticks, since_rel, grants = 0;
    logic [NCH-1:0] p_req;
    logic p_busy, p_cen, p_bgn, p_asn;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NCH-1:0] oh(input int c);
        return NCH'(1) << c;
    endfunction

    function automatic int rr_pick(input int last, input logic [NCH-1:0] r);
        for (int k = 1; k <= NCH; k++)
            if (r[(last + k) % NCH]) return (last + k) % NCH;
        return -1;
    endfunction

    task automatic drive_data();
        cpu_addr = AW'($urandom); cpu_dsn = 2'($urandom); cpu_rnw = 1'($urandom); cpu_dout = DW'($urandom);
        for (int i = 0; i < NCH; i++) begin
            ea[i] = AW'($urandom); ed[i] = 2'($urandom); er[i] = 1'($urandom); eo[i] = DW'($urandom);
            ext_addr[i*AW +: AW] = ea[i];
            ext_dsn[i*2 +: 2]    = ed[i];
            ext_rnw[i]           = er[i];
            ext_dout[i*DW +: DW] = eo[i];
        end
    endtask

    // One clk of stimulus: record the arbiter's pick, run the requesters and the CPU.
    task automatic step(input bit gen);
        int ch;
        @(posedge clk); #1;
        if (prev_brn && !cpu_BRn) begin
            ch = rr_pick(m_last, req);
            saved_last = m_last; m_last = ch; pend = ch;
            exp_q.push_back(ch);
        end
        prev_brn = cpu_BRn;
        for (int i = 0; i < NCH; i++) begin
            if (req[i] && gnt[i]) begin
                served[i]++;
                if (served[i] >= len[i]) req[i] = 1'b0;
            end else if (cool[i] > 0) cool[i]--;
            else if (gen && !req[i] && !gnt[i] && $urandom_range(7) == 0) begin
                req[i] = 1'b1; len[i] = int'($urandom_range(12, 1)); served[i] = 0;
            end
        end
        if (gen && !cpu_BRn && gnt == '0 && pend >= 0 && req[pend] && $urandom_range(39) == 0) begin
            req[pend] = 1'b0; cool[pend] = 20;
            void'(exp_q.pop_back());
            m_last = saved_last; pend = -1;
        end
        br_ticks = cpu_BRn ? 0 : br_ticks + (last_cen ? 1 : 0);
        cpu_BGn  = !(!cpu_BRn && br_ticks >= 2);
        cpu_ASn  = cpu_BGACKn ? ($urandom_range(2) != 0) : 1'b1;
        last_cen = cen;
        cen      = gen ? ($urandom_range(3) != 0) : 1'b1;
        bus_busy = ($urandom_range(3) == 0);
        drive_data();
    endtask

    // Monitor: inputs latched at the previous negedge are what the DUT sampled on this posedge.
    always @(negedge clk) begin
        int e;
        if (!mon_en) begin
            own = 1'b0; prev_own = 1'b0; since_rel = 100;
        end else begin
            if (!own && gnt != '0) begin
                chk("grant_pending", exp_q.size() != 0, 1);
                e = exp_q.size() != 0 ? exp_q.pop_front() : 0;
                chk("grant_onehot", gnt, oh(e));
                chk("grant_cond", {p_cen, p_bgn, p_asn}, 3'b101);
                chk("grant_brn", cpu_BRn, 1);
                chk("grant_gap", since_rel >= GAP + 1, 1);
                own = 1'b1; own_ch = e; ticks = 0; grants++;
            end else if (own && p_cen) begin
                ticks = ticks < 255 ? ticks + 1 : 255;
                if (!p_req[own_ch] || (ticks >= MAXTEN && (p_req & ~oh(own_ch)) != '0 && !p_busy)) begin
                    own = 1'b0; since_rel = 0;
                end
            end else if (!own && p_cen) since_rel++;
            chk("gnt", gnt, own ? oh(own_ch) : '0);
            chk("bgackn", cpu_BGACKn, !own);
            chk("ext_ok", ext_ok, (own && prev_own) ? (oh(own_ch) & {NCH{~bus_busy}}) : '0);
            chk("bus_mux", {bus_addr, bus_dsn, bus_rnw, bus_dout},
                own ? {ea[own_ch], ed[own_ch], er[own_ch], eo[own_ch]}
                    : {cpu_addr, cpu_dsn, cpu_rnw, cpu_dout});
            prev_own = own;
        end
        p_req = req; p_busy = bus_busy; p_cen = cen; p_bgn = cpu_BGn; p_asn = cpu_ASn;
    end

    task automatic model_reset();
        exp_q.delete();
        m_last = NCH - 1; saved_last = NCH - 1; pend = -1;
        prev_brn = 1'b1; br_ticks = 0; last_cen = 1'b1;
        for (int i = 0; i < NCH; i++) begin served[i] = 0; cool[i] = 0; len[i] = 1; end
    endtask

    initial begin
        rst = 1'b1; cen = 1'b1; cpu_ASn = 1'b1; cpu_BGn = 1'b1; bus_busy = 1'b0; req = '0;
        drive_data();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_brn", cpu_BRn, 1);
        chk("reset_bgackn", cpu_BGACKn, 1);
        chk("reset_gnt", gnt, 0);
        chk("reset_ok", ext_ok, 0);
        chk("reset_mux", bus_addr, cpu_addr);
        @(posedge clk); #1;
        rst = 1'b0; mon_en = 1'b1;
        // All three channels asking at once: rotation starts at channel 0.
        req = '1;
        for (int i = 0; i < NCH; i++) len[i] = 10;
        repeat (2000) step(1'b1);
        repeat (400) step(1'b0);
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_req", req, 0);
        chk("grant_count", grants >= 20, 1);

        req = 3'b001; len[0] = 100000; served[0] = 0;
        for (int t = 0; t < 400 && gnt == '0; t++) step(1'b0);
        chk("own_before_rst", gnt, 3'b001);
        mon_en = 1'b0; rst = 1'b1; req = '0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_own_brn", cpu_BRn, 1);
        chk("rst_own_bgackn", cpu_BGACKn, 1);
        chk("rst_own_gnt", gnt, 0);
        chk("rst_own_ok", ext_ok, 0);
        chk("rst_own_mux", bus_addr, cpu_addr);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        mon_en = 1'b1;
        req = 3'b011; len[0] = 3; len[1] = 3;
        repeat (200) step(1'b0);
        chk("post_rst_queue", exp_q.size(), 0);
        chk("post_rst_req", req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
